// File: rtl/deserializer.sv
// deserializer: assembles an LSB-first serial frame of max_count+1 bits into a parallel word
// and presents it on a valid/ready output with overrun and frame-abort reporting.
module deserializer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             sdata,
   input  logic             svalid,
   input  logic             sstart,
   input  logic [4:0]       max_count,
   output logic [WIDTH-1:0] pdata,
   output logic             pvalid,
   input  logic             pready,
   output logic             busy,
   output logic [4:0]       count,
   output logic             overrun,
   output logic             frame_err
);
   typedef enum logic {S_IDLE, S_SHIFT} state_t;
   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shift, r_pdata;
   logic [4:0]       r_len, r_count;
   logic             r_done, r_pvalid, r_overrun, r_frame_err;
   logic             w_start, w_bit, w_last, w_done;
   assign w_start = svalid && sstart;
   assign w_bit   = svalid && !sstart && (r_state == S_SHIFT);
   assign w_last  = w_bit && (r_count == r_len);
   assign w_done  = (w_start && (max_count == 5'd0)) || w_last;
   always_comb begin
      w_state_nxt = r_state;
      if (w_start)
         w_state_nxt = (max_count == 5'd0) ? S_IDLE : S_SHIFT;
      else if (w_last)
         w_state_nxt = S_IDLE;
   end
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end
   // a start clears the shift register so bits above the frame length read as zero
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_shift     <= '0;
         r_len       <= '0;
         r_count     <= '0;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_start) begin
            r_shift <= WIDTH'(sdata);
            r_len   <= max_count;
            r_count <= (max_count == 5'd0) ? 5'd0 : 5'd1;
         end else if (w_bit) begin
            r_shift[r_count] <= sdata;
            r_count          <= w_last ? 5'd0 : r_count + 5'd1;
         end
         r_done      <= w_done;
         r_frame_err <= w_start && (r_state == S_SHIFT);
      end
   end
   // a finished word is dropped only when the held word is not being consumed this cycle
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_pdata   <= '0;
         r_pvalid  <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_done) begin
            if (!r_pvalid || pready) begin
               r_pdata  <= r_shift;
               r_pvalid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (pready) begin
            r_pvalid <= 1'b0;
         end
      end
   end
   assign pdata     = r_pdata;
   assign pvalid    = r_pvalid;
   assign busy      = (r_state == S_SHIFT);
   assign count     = r_count;
   assign overrun   = r_overrun;
   assign frame_err = r_frame_err;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed frames with hand-computed expected words and handshake flags.
module tb_deserializer;
   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        sdata = 1'b0, svalid = 1'b0, sstart = 1'b0, pready = 1'b0;
   logic [4:0]  max_count = 5'd0;
   logic [31:0] pdata;
   logic        pvalid, busy, overrun, frame_err;
   logic [4:0]  count;
   int          n_chk = 0, n_bad = 0;

   deserializer #(.WIDTH(32)) dut (
      .clk(clk), .resetN(resetN), .sdata(sdata), .svalid(svalid), .sstart(sstart),
      .max_count(max_count), .pdata(pdata), .pvalid(pvalid), .pready(pready),
      .busy(busy), .count(count), .overrun(overrun), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // inputs are applied at a negedge and held through the following posedge
   task automatic drive(input logic v, input logic s, input logic d);
      svalid = v;
      sstart = s;
      sdata  = d;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_bits(input logic [4:0] mc, input logic [31:0] w,
                            input int first, input int last, input bit gap);
      for (int i = first; i <= last; i++) begin
         if (gap && i > first) idle();
         max_count = mc;
         drive(1'b1, i == 0, w[i]);
      end
      idle_inputs();
   endtask

   task automatic idle_inputs();
      svalid = 1'b0;
      sstart = 1'b0;
      sdata  = 1'b0;
   endtask

   initial begin
      #12;
      check("rst_pdata", pdata, 32'h0);
      check("rst_pvalid", {31'b0, pvalid}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_count", {27'b0, count}, 32'h0);
      check("rst_flags", {30'b0, overrun, frame_err}, 32'h0);
      @(negedge clk);
      resetN = 1'b1;

      // basic frame
      send_bits(5'd7, 32'hA5, 0, 2, 1'b0);
      check("basic_cnt3", {27'b0, count}, 32'd3);
      check("basic_busy", {31'b0, busy}, 32'd1);
      send_bits(5'd7, 32'hA5, 3, 7, 1'b0);
      check("basic_lat", {31'b0, pvalid}, 32'd0);
      check("basic_cnt0", {27'b0, count}, 32'd0);
      check("basic_idle", {31'b0, busy}, 32'd0);
      idle();
      check("basic_pvalid", {31'b0, pvalid}, 32'd1);
      check("basic_pdata", pdata, 32'h0000_00A5);
      pready = 1'b1;
      idle();
      check("basic_consumed", {31'b0, pvalid}, 32'd0);
      pready = 1'b0;

      // gapped input
      send_bits(5'd7, 32'hA5, 0, 3, 1'b1);
      check("gap_cnt4", {27'b0, count}, 32'd4);
      idle();
      idle();
      check("gap_hold", {27'b0, count}, 32'd4);
      send_bits(5'd7, 32'hA5, 4, 7, 1'b1);
      idle();
      check("gap_pdata", pdata, 32'h0000_00A5);
      pready = 1'b1;
      idle();
      pready = 1'b0;

      // backpressure / overrun
      send_bits(5'd7, 32'h3C, 0, 7, 1'b0);
      idle();
      check("bp_first", pdata, 32'h3C);
      send_bits(5'd7, 32'hC3, 0, 7, 1'b0);
      check("bp_no_ovr_yet", {31'b0, overrun}, 32'd0);
      idle();
      check("bp_overrun", {31'b0, overrun}, 32'd1);
      check("bp_pdata_kept", pdata, 32'h3C);
      check("bp_pvalid", {31'b0, pvalid}, 32'd1);
      idle();
      check("bp_ovr_pulse", {31'b0, overrun}, 32'd0);
      pready = 1'b1;
      idle();
      check("bp_consumed", {31'b0, pvalid}, 32'd0);
      pready = 1'b0;

      // simultaneous consume and load
      send_bits(5'd7, 32'h3C, 0, 7, 1'b0);
      idle();
      send_bits(5'd7, 32'hC3, 0, 7, 1'b0);
      pready = 1'b1;
      idle();
      pready = 1'b0;
      check("sim_pdata", pdata, 32'hC3);
      check("sim_pvalid", {31'b0, pvalid}, 32'd1);
      check("sim_no_ovr", {31'b0, overrun}, 32'd0);
      idle();
      check("sim_held", {31'b0, pvalid}, 32'd1);
      pready = 1'b1;
      idle();
      pready = 1'b0;

      // abort and restart
      send_bits(5'd7, 32'h05, 0, 3, 1'b0);
      check("abort_partial", {27'b0, count}, 32'd4);
      send_bits(5'd7, 32'hFF, 0, 0, 1'b0);
      check("abort_ferr", {31'b0, frame_err}, 32'd1);
      check("abort_cnt1", {27'b0, count}, 32'd1);
      send_bits(5'd7, 32'hFF, 1, 7, 1'b0);
      check("abort_ferr_pulse", {31'b0, frame_err}, 32'd0);
      idle();
      check("abort_pdata", pdata, 32'hFF);
      pready = 1'b1;
      idle();
      pready = 1'b0;

      // single-bit frame
      send_bits(5'd0, 32'h1, 0, 0, 1'b0);
      check("one_busy", {31'b0, busy}, 32'd0);
      check("one_cnt", {27'b0, count}, 32'd0);
      idle();
      check("one_pvalid", {31'b0, pvalid}, 32'd1);
      check("one_pdata", pdata, 32'h1);
      pready = 1'b1;
      idle();
      pready = 1'b0;

      // full-width frame
      send_bits(5'd31, 32'hDEADBEEF, 0, 31, 1'b0);
      idle();
      check("full_pdata", pdata, 32'hDEADBEEF);
      pready = 1'b1;
      idle();
      pready = 1'b0;

      // asynchronous reset mid-frame
      send_bits(5'd15, 32'h1234, 0, 9, 1'b0);
      check("rst_mid_busy", {31'b0, busy}, 32'd1);
      resetN = 1'b0;
      #1;
      check("arst_pdata", pdata, 32'h0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_count", {27'b0, count}, 32'd0);
      check("arst_pvalid", {31'b0, pvalid}, 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      send_bits(5'd7, 32'h5A, 0, 7, 1'b0);
      idle();
      check("post_rst_pdata", pdata, 32'h5A);
      check("post_rst_pvalid", {31'b0, pvalid}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
